mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative RV32M multiply/divide unit sitting beside the single-cycle `alu` in the EX stage. It:
- accepts one M-extension operation from the pipeline over a valid/ready request port;
- computes it over a fixed number of cycles while the hazard unit stalls the pipeline;
- returns the 32-bit result with a one-cycle response pulse.

It is the multi-cycle responder the pipeline issues to whenever the decoded instruction's funct7 is 0000001.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk`, input, 1: rising-edge clock.
- `rstn`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, 1: pipeline presents an operation.
- `req_ready`, output, 1: unit is idle and can accept.
- `req_op`, input, 3: RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `req_a`, input, 32: rs1 operand (post-forwarding).
- `req_b`, input, 32: rs2 operand (post-forwarding).
- `flush`, input, 1: kill the in-flight operation (branch/exception squash).
- `busy`, output, 1: operation in flight; the hazard unit stalls on it.
- `resp_valid`, output, 1: result valid this cycle (one-cycle pulse, no backpressure).
- `resp_result`, output, 32: result, held until the next response.

## Operation
- States:
  - IDLE: `req_ready`=1, `busy`=0.
  - CALC: 32 iterations.
  - FIX: sign correction and result select.
  - DONE: `resp_valid`=1.
- Acceptance: `req_valid & req_ready` at a rising edge. On acceptance, latch `req_op`, `req_a`, `req_b`, the operand sign flags and the operand magnitudes. Zero the 64-bit accumulator/remainder and the 5-bit counter.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - Magnitude of a negative operand is two's-complement negation. Magnitude of 0x80000000 is 2^31, which is handled as an unsigned 32-bit value.
- Multiply (CALC): shift-add, LSB of multiplier first, into a 64-bit product.
- Divide (CALC): restoring, MSB of dividend first, with a 33-bit trial subtract; produces quotient and remainder magnitudes.
- FIX:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Result select: MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32]; DIV/DIVU take the quotient; REM/REMU take the remainder.
- Special cases are detected at acceptance and go IDLE→DONE directly:
  - Divide by zero (B=0): DIV/DIVU → 0xFFFFFFFF; REM/REMU → A.
  - Signed overflow (DIV/REM with A=0x80000000, B=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- DONE → IDLE unconditionally after one cycle.
- Flush:
  - Asserted in CALC or FIX: go to IDLE at the next edge, with no response and `resp_result` unchanged.
  - Asserted together with an acceptable request in IDLE: the request is dropped, because flush has priority.
  - Asserted in DONE: it does not retract the already-visible `resp_valid`.
- Reset mid-operation: immediate return to IDLE and all outputs to their reset values; the in-flight operation is lost.

## Timing
- Reset values: state IDLE, `busy`=0, `resp_valid`=0, `resp_result`=0, counter 0. `req_ready`=1 while in IDLE, including during reset, but no acceptance occurs while `rstn` is low.
- `req_ready` and `busy` are decoded from the state register; `resp_valid` and `resp_result` are registered outputs.
- Normal latency, with acceptance edge ending cycle 0:
  - Cycles 1–32: CALC.
  - Cycle 33: FIX.
  - Cycle 34: DONE, `resp_valid`=1.
  - Cycle 35: IDLE, `req_ready`=1.
  - Throughput is one operation per 35 cycles.
- Special-case latency: `resp_valid` in cycle 1; `req_ready` again in cycle 2.
- `busy`=1 in every non-IDLE state except DONE, so the stall releases in the same cycle the result is consumed.
- `resp_result` updates only on entry to DONE.

## Structure
- Add `MDUOp_*` funct3 defines and the state encodings (`MDU_IDLE`/`MDU_CALC`/`MDU_FIX`/`MDU_DONE`, 2 bits) to `ctrl_encode_def.v` beside the `ALUOp_*` defines.
- Single module; no sub-module needed. Multiply and divide share the 64-bit shift register and the 33-bit adder/subtractor, selected by `req_op[2]`.

## Test plan
- MUL 7 × −3 (A=7, B=0xFFFFFFFD) → `resp_result`=0xFFFFFFEB, `resp_valid` exactly in cycle 34, `busy` high in cycles 1–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, each with `resp_valid` in cycle 1; DIV 0x80000000/−1 → 0x80000000 and REM → 0.
- Flush asserted in cycle 10 of a DIVU → IDLE in cycle 11, no `resp_valid`, `resp_result` keeps its prior value; a new MUL 3×4 accepted in cycle 11 returns 12 in cycle 45.
- `rstn` pulsed low in cycle 20 of a MUL → `busy`, `resp_valid` and `resp_result` go to 0 immediately; no response is ever produced for that operation.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter_pkg
// Description : Shared encodings for the iterative RV32M multiply/divide unit:
//               funct3 operation codes, FSM states and signedness helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_iter_pkg;

  // RV32M funct3 operation codes
  localparam logic [2:0] MDUOP_MUL    = 3'b000;
  localparam logic [2:0] MDUOP_MULH   = 3'b001;
  localparam logic [2:0] MDUOP_MULHSU = 3'b010;
  localparam logic [2:0] MDUOP_MULHU  = 3'b011;
  localparam logic [2:0] MDUOP_DIV    = 3'b100;
  localparam logic [2:0] MDUOP_DIVU   = 3'b101;
  localparam logic [2:0] MDUOP_REM    = 3'b110;
  localparam logic [2:0] MDUOP_REMU   = 3'b111;

  // Sequencer states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2,
    MDU_DONE = 2'd3
  } mdu_state_t;

  // rs1 is treated as signed for everything except the fully unsigned ops
  function automatic logic mdu_signed_a(input logic [2:0] op);
    return !(op == MDUOP_MULHU || op == MDUOP_DIVU || op == MDUOP_REMU);
  endfunction

  // rs2 is signed only for MUL, MULH, DIV and REM
  function automatic logic mdu_signed_b(input logic [2:0] op);
    return (op == MDUOP_MUL || op == MDUOP_MULH ||
            op == MDUOP_DIV || op == MDUOP_REM);
  endfunction

endpackage : mdu_iter_pkg
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative RV32M multiply/divide unit. Shift-add multiply and
//               restoring divide over 32 cycles on magnitudes, followed by a
//               sign-fix cycle. Divide-by-zero and signed overflow bypass the
//               iteration and respond in the cycle after acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_result
);

  localparam logic [XLEN-1:0] C_MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        r_state;
  mdu_state_t        w_next;
  logic [2:0]        r_op;
  logic              r_sa;
  logic              r_sb;
  logic [XLEN-1:0]   r_ma;
  logic [XLEN-1:0]   r_mb;
  logic [2*XLEN-1:0] r_acc;
  logic [4:0]        r_cnt;

  logic              w_accept;
  logic              w_sa_in;
  logic              w_sb_in;
  logic              w_div0;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic              w_is_div;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN+1:0]   w_opa;
  logic [XLEN+1:0]   w_opb;
  logic [XLEN+1:0]   w_sum;
  logic              w_borrow;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix;

  assign req_ready = (r_state == MDU_IDLE);
  assign busy      = (r_state == MDU_CALC) || (r_state == MDU_FIX);

  // Flush wins over a simultaneous request
  assign w_accept  = req_valid && req_ready && !flush;
  assign w_sa_in   = mdu_signed_a(req_op) & req_a[XLEN-1];
  assign w_sb_in   = mdu_signed_b(req_op) & req_b[XLEN-1];
  assign w_div0    = req_op[2] && (req_b == '0);
  assign w_ovf     = req_op[2] && !req_op[0] && (req_a == C_MIN_NEG) && (req_b == '1);
  assign w_special = w_div0 || w_ovf;
  assign w_special_res = w_div0 ? (req_op[1] ? req_a : '1)
                                : (req_op[1] ? '0 : C_MIN_NEG);

  // Shared 34-bit adder/subtractor: add for multiply, trial subtract for divide
  assign w_is_div    = r_op[2];
  assign w_div_shift = {r_acc[2*XLEN-1:XLEN], r_ma[5'd31 - r_cnt]};
  assign w_opa = w_is_div ? {1'b0, w_div_shift} : {2'b00, r_acc[2*XLEN-1:XLEN]};
  assign w_opb = w_is_div ? {2'b00, r_mb} : {2'b00, (r_mb[r_cnt] ? r_ma : '0)};
  assign w_sum = w_opa + (w_opb ^ {(XLEN+2){w_is_div}}) + {{(XLEN+1){1'b0}}, w_is_div};
  // Values stay below 2^33, so bit 33 is the sign of the trial difference
  assign w_borrow = w_sum[XLEN+1];

  // Multiply shifts the product right; divide shifts remainder/quotient left
  assign w_acc_next = w_is_div
      ? {(w_borrow ? w_div_shift[XLEN-1:0] : w_sum[XLEN-1:0]), r_acc[XLEN-2:0], !w_borrow}
      : {w_sum[XLEN:0], r_acc[XLEN-1:1]};

  // Sign correction of the magnitude results
  assign w_prod = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = (r_sa ^ r_sb) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];

  // Result select by operation
  always_comb begin
    w_fix = w_prod[2*XLEN-1:XLEN];
    case (r_op)
      MDUOP_MUL:              w_fix = w_prod[XLEN-1:0];
      MDUOP_DIV, MDUOP_DIVU:  w_fix = w_quo;
      MDUOP_REM, MDUOP_REMU:  w_fix = w_rem;
      default:                w_fix = w_prod[2*XLEN-1:XLEN];
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= MDU_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      MDU_IDLE: if (w_accept) w_next = w_special ? MDU_DONE : MDU_CALC;
      MDU_CALC: if (flush) w_next = MDU_IDLE;
                else if (r_cnt == 5'd31) w_next = MDU_FIX;
      MDU_FIX:  w_next = flush ? MDU_IDLE : MDU_DONE;
      MDU_DONE: w_next = MDU_IDLE;
      default:  w_next = MDU_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op        <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (w_accept) begin
        r_op  <= req_op;
        r_sa  <= w_sa_in;
        r_sb  <= w_sb_in;
        r_ma  <= w_sa_in ? (~req_a + 1'b1) : req_a;
        r_mb  <= w_sb_in ? (~req_b + 1'b1) : req_b;
        r_acc <= '0;
        r_cnt <= '0;
        if (w_special) begin
          resp_valid  <= 1'b1;
          resp_result <= w_special_res;
        end
      end else if (r_state == MDU_CALC && !flush) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 5'd1;
      end else if (r_state == MDU_FIX && !flush) begin
        resp_valid  <= 1'b1;
        resp_result <= w_fix;
      end
    end
  end

endmodule : mdu_iter
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_iter
// Description : Directed self-checking bench for mdu_iter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        flush;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_result;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_iter #(.XLEN(32)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .flush      (flush),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op from an IDLE sample point, wait for the response and check
  // result, latency (cycles after the acceptance edge) and busy cycle count.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    int busy_cnt;
    logic [31:0] res;
    lat = 0; busy_cnt = 0; res = 'x;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cnt++;
      if (resp_valid) begin
        lat = c;
        res = resp_result;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, " result"}, res, exp_res);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, (exp_lat == 34) ? 33 : 0);
    @(posedge clk); #1;
    check({tag, " ready after"}, {31'd0, req_ready}, 32'd1);
    check({tag, " pulse width"}, {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    rstn = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; flush = 1'b0;
    #12;
    check("rst busy",   {31'd0, busy},       32'd0);
    check("rst rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst result", resp_result,         32'd0);
    check("rst ready",  {31'd0, req_ready},  32'd1);
    #10 rstn = 1'b1;
    @(posedge clk); #1;

    run_op("MUL 7*-3",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("MULH min^2",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("MULHU -1^2",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("MULHSU",      3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("DIV -7/2",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("REM -7/2",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("DIVU 100/7",  3'b101, 32'd100,      32'd7,        32'd14,       34);
    run_op("REMU 100/7",  3'b111, 32'd100,      32'd7,        32'd2,        34);
    run_op("DIV 5/0",     3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("REM 5/0",     3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("DIVU 5/0",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("DIV ovf",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("DIV min/2",   3'b100, 32'h80000000, 32'd2,        32'hC0000000, 34);

    // Flush a DIVU in cycle 10
    req_op = 3'b101; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    for (int c = 1; c <= 9; c++) begin
      if (resp_valid) seen++;
      @(posedge clk); #1;
    end
    check("flush busy c10", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush busy c11",   {31'd0, busy},       32'd0);
    check("flush ready c11",  {31'd0, req_ready},  32'd1);
    check("flush no resp",    {31'd0, resp_valid}, 32'd0);
    check("flush early resp", seen,                32'd0);
    check("flush result kept", resp_result,        32'hC0000000);
    run_op("MUL 3*4 after flush", 3'b000, 32'd3, 32'd4, 32'd12, 34);

    // Reset in cycle 20 of a MUL
    req_op = 3'b000; req_a = 32'd5; req_b = 32'd6; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
    end
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #1;
    check("mid-rst busy",   {31'd0, busy},       32'd0);
    check("mid-rst rvalid", {31'd0, resp_valid}, 32'd0);
    check("mid-rst result", resp_result,         32'd0);
    check("mid-rst ready",  {31'd0, req_ready},  32'd1);
    @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (resp_valid || busy) seen++;
    end
    check("post-rst no resp", seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mdu_iter
`default_nettype wire
